mem_slot_scheduler: RTL and testbench
=====================================

// Module: mem_slot_scheduler
// PURPOSE
//  Shares the single RAM/ROM data bus between video, sound, floppy (IWM int/ext) and the 68000.
//  Time is divided into fixed bus slots of SLOT_TICKS clk8 ticks; one owner is granted per slot.
//  Drives videoBusControl/cpuBusControl/memoryLatch consumed by dataController_top and the muxes.
// PARAMETERS
//  SLOT_TICKS    4  clk8_en_p ticks per slot (legal range 2..8); latch occurs in the last tick
//  CPU_MAX_WAIT  3  consecutive lost slots after which a waiting CPU is forced in (CPU_MIN_SHARE_EN only)
// PORTS
//  clk32            in   1  32.5 MHz system clock
//  _reset           in   1  asynchronous, active-low reset
//  clk8_en_p        in   1  clk8 rising-phase enable
//  clk8_en_n        in   1  clk8 falling-phase enable
//  video_req        in   1  video shifter needs a word (level)
//  snd_req          in   1  sound/PWM word needed (level)
//  dsk_int_req      in   1  internal-drive read pending (level, held until ack)
//  dsk_ext_req      in   1  external-drive read pending (level, held until ack)
//  cpu_req          in   1  CPU memory cycle pending (AS asserted, RAM/ROM decoded)
//  videoBusControl  out  1  video owns current slot
//  cpuBusControl    out  1  CPU owns current slot
//  memoryLatch      out  1  one-clk32 strobe: data bus valid for owner
//  owner            out  3  mem_slot_pkg::owner_t of current slot (address-mux select)
//  snd_ack          out  1  one-clk32 pulse with memoryLatch when sound owned slot
//  dsk_int_ack      out  1  one-clk32 pulse, internal drive
//  dsk_ext_ack      out  1  one-clk32 pulse, external drive
//  slot_start       out  1  one-clk32 pulse on first tick of every slot
// BEHAVIOUR
//  - Reset (async, _reset=0): tick counter 0, owner=OWN_NONE, all outputs 0, RR pointer->INT, wait count 0.
//  - Tick counter advances on clk8_en_p, wraps SLOT_TICKS-1 -> 0; the wrap is the slot boundary.
//  - Arbitration on the boundary clk8_en_p edge using requests sampled that cycle; owner held whole slot.
//  - Priority: video > snd > disk > cpu > none. Disk: INT/EXT round-robin, pointer toggles only on disk grant.
//  - videoBusControl = (owner==OWN_VIDEO); cpuBusControl = (owner==OWN_CPU); registered, change only at boundary.
//  - memoryLatch: high exactly one clk32 cycle, the first clk8_en_n with tick==SLOT_TICKS-1 and owner!=NONE.
//  - Acks coincide with memoryLatch for their owner; requester must drop req before next boundary or is re-granted.
//  - Idle slot (no req): owner=NONE, no latch, no ack; slot_start still pulses.
//  - Requests rising mid-slot wait for next boundary; a req dropped mid-slot does not abort the slot.
//  - Simultaneous all-req: video wins; others wait; none are lost (levels).
//  - Reset mid-slot: immediate return to reset state; no partial ack/latch issued afterwards.
// CONFIGURATION
//  MEM_SLOT_CPU_MIN_SHARE_EN defined: wait counter increments per boundary where cpu_req=1 and CPU not
//   granted; on reaching CPU_MAX_WAIT, CPU outranks snd/disk (never video) next slot; counter clears on CPU grant
//   or cpu_req=0. Saturates at CPU_MAX_WAIT.
//  Undefined: pure fixed priority; counter logic absent; CPU may starve while snd/disk pending.
// STRUCTURE
//  mem_slot_pkg: owner_t enum {OWN_NONE,OWN_VIDEO,OWN_SND,OWN_DSK_INT,OWN_DSK_EXT,OWN_CPU} (3 bits),
//   function tick_w(SLOT_TICKS), localparam LAST_TICK.
//  Sub-module mem_slot_tick: tick counter + slot_start/last-tick flags; arbiter/latch logic in top.
// TESTING
//  1 Only cpu_req=1, SLOT_TICKS=4 -> owner=CPU every slot, memoryLatch once per 4 clk8 ticks, cpuBusControl=1.
//  2 video_req,snd_req,cpu_req all 1 at one boundary -> slot VIDEO; drop video -> SND next; then CPU.
//  3 dsk_int_req,dsk_ext_req held -> grants alternate INT,EXT,INT; acks pulse one clk32 each with latch.
//  4 MIN_SHARE_EN, CPU_MAX_WAIT=3, snd+disk+cpu held -> 3 non-CPU slots then CPU in slot 4; repeat.
//  5 _reset low at tick 2 of a CPU slot -> all outputs 0 same cycle; no memoryLatch until a full new slot.
//  6 No requests for 10 slots -> owner=NONE, memoryLatch never asserted, slot_start pulses 10 times.

Source files
------------

// File: rtl/mem_slot_pkg.sv
// Shared types and helpers for the memory bus slot scheduler.
package mem_slot_pkg;

  typedef enum logic [2:0] {
    OWN_NONE    = 3'd0,
    OWN_VIDEO   = 3'd1,
    OWN_SND     = 3'd2,
    OWN_DSK_INT = 3'd3,
    OWN_DSK_EXT = 3'd4,
    OWN_CPU     = 3'd5
  } owner_t;

  localparam int DEFAULT_SLOT_TICKS = 4;
  localparam int LAST_TICK          = DEFAULT_SLOT_TICKS - 1;

  // Width of a counter holding 0..slot_ticks-1 (at least one bit).
  function automatic int tick_w(input int slot_ticks);
    return (slot_ticks <= 2) ? 1 : $clog2(slot_ticks);
  endfunction

endpackage

// File: rtl/mem_slot_tick.sv
// Slot timebase: counts clk8 rising-phase ticks and flags the last tick and slot boundary.
module mem_slot_tick
  import mem_slot_pkg::*;
#(
  parameter int SLOT_TICKS = LAST_TICK + 1
) (
  input  logic clk32,
  input  logic _reset,
  input  logic clk8_en_p,
  output logic last_tick,
  output logic boundary,
  output logic slot_start
);

  localparam int              TW     = tick_w(SLOT_TICKS);
  localparam logic [TW-1:0]   LAST_T = TW'(SLOT_TICKS - 1);

  logic [TW-1:0] tick;

  assign last_tick = (tick == LAST_T);
  assign boundary  = clk8_en_p && last_tick;

  // NOTE: flops use non-blocking assignments so every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk32 or negedge _reset) begin
    if (!_reset) begin
      tick       <= '0;
      slot_start <= 1'b0;
    end else begin
      slot_start <= boundary;
      if (boundary)
        tick <= '0;
      else if (clk8_en_p)
        tick <= tick + 1'b1;
    end
  end

endmodule

// File: rtl/mem_slot_scheduler.sv
// Time-slotted owner arbiter for the shared RAM/ROM bus (video, sound, floppy, 68000).
// Optional MEM_SLOT_CPU_MIN_SHARE_EN adds a wait counter that forces a starved CPU in.
module mem_slot_scheduler
  import mem_slot_pkg::*;
#(
  parameter int SLOT_TICKS = LAST_TICK + 1
`ifdef MEM_SLOT_CPU_MIN_SHARE_EN
  , parameter int CPU_MAX_WAIT = 3
`endif
) (
  input  logic   clk32,
  input  logic   _reset,
  input  logic   clk8_en_p,
  input  logic   clk8_en_n,
  input  logic   video_req,
  input  logic   snd_req,
  input  logic   dsk_int_req,
  input  logic   dsk_ext_req,
  input  logic   cpu_req,
  output logic   videoBusControl,
  output logic   cpuBusControl,
  output logic   memoryLatch,
  output owner_t owner,
  output logic   snd_ack,
  output logic   dsk_int_ack,
  output logic   dsk_ext_ack,
  output logic   slot_start
);

  logic   last_tick;
  logic   boundary;
  logic   rr_ext;       // 1: external drive preferred on the next contested disk grant
  logic   force_cpu;
  logic   latch_done;
  logic   latch_fire;
  owner_t next_owner;

  mem_slot_tick #(.SLOT_TICKS(SLOT_TICKS)) u_tick (
    .clk32      (clk32),
    ._reset     (_reset),
    .clk8_en_p  (clk8_en_p),
    .last_tick  (last_tick),
    .boundary   (boundary),
    .slot_start (slot_start)
  );

`ifdef MEM_SLOT_CPU_MIN_SHARE_EN
  localparam int               WAIT_W   = $clog2(CPU_MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(CPU_MAX_WAIT);

  logic [WAIT_W-1:0] wait_cnt;

  always_ff @(posedge clk32 or negedge _reset) begin
    if (!_reset)
      wait_cnt <= '0;
    else if (boundary) begin
      if (!cpu_req || next_owner == OWN_CPU)
        wait_cnt <= '0;
      else if (wait_cnt != WAIT_MAX)
        wait_cnt <= wait_cnt + 1'b1;
    end
  end

  assign force_cpu = (wait_cnt == WAIT_MAX);
`else
  assign force_cpu = 1'b0;
`endif

  // NOTE: next_owner gets a default before the priority chain so no path leaves it unassigned (no inferred latch).
  always_comb begin
    next_owner = OWN_NONE;
    if (video_req)
      next_owner = OWN_VIDEO;
    else if (force_cpu && cpu_req)
      next_owner = OWN_CPU;
    else if (snd_req)
      next_owner = OWN_SND;
    else if (dsk_int_req && (!dsk_ext_req || !rr_ext))
      next_owner = OWN_DSK_INT;
    else if (dsk_ext_req)
      next_owner = OWN_DSK_EXT;
    else if (cpu_req)
      next_owner = OWN_CPU;
  end

  always_ff @(posedge clk32 or negedge _reset) begin
    if (!_reset) begin
      owner           <= OWN_NONE;
      videoBusControl <= 1'b0;
      cpuBusControl   <= 1'b0;
      rr_ext          <= 1'b0;
    end else if (boundary) begin
      owner           <= next_owner;
      videoBusControl <= (next_owner == OWN_VIDEO);
      cpuBusControl   <= (next_owner == OWN_CPU);
      if (next_owner == OWN_DSK_INT || next_owner == OWN_DSK_EXT)
        rr_ext <= ~rr_ext;
    end
  end

  // Latch strobe and acks are registered off the first falling phase of the last tick.
  assign latch_fire = clk8_en_n && last_tick && (owner != OWN_NONE) && !latch_done;

  always_ff @(posedge clk32 or negedge _reset) begin
    if (!_reset) begin
      memoryLatch <= 1'b0;
      snd_ack     <= 1'b0;
      dsk_int_ack <= 1'b0;
      dsk_ext_ack <= 1'b0;
      latch_done  <= 1'b0;
    end else begin
      memoryLatch <= latch_fire;
      snd_ack     <= latch_fire && (owner == OWN_SND);
      dsk_int_ack <= latch_fire && (owner == OWN_DSK_INT);
      dsk_ext_ack <= latch_fire && (owner == OWN_DSK_EXT);
      if (boundary)
        latch_done <= 1'b0;
      else if (latch_fire)
        latch_done <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_slot_scheduler.sv
// Scoreboard bench for mem_slot_scheduler: per-slot expected owners, monitor checks each memoryLatch.
`timescale 1ns/1ps
module tb_mem_slot_scheduler;
  import mem_slot_pkg::*;

  logic   clk32 = 1'b0;
  logic   _reset;
  logic   clk8_en_p = 1'b0;
  logic   clk8_en_n = 1'b0;
  logic   video_req, snd_req, dsk_int_req, dsk_ext_req, cpu_req;
  logic   videoBusControl, cpuBusControl, memoryLatch;
  owner_t owner;
  logic   snd_ack, dsk_int_ack, dsk_ext_ack, slot_start;

  int     total = 0;
  int     bad = 0;
  int     latch_cnt = 0;
  int     push_cnt = 0;
  logic   latch_forbidden = 1'b0;
  owner_t sb_q[$];
  owner_t mon_exp;

`ifdef MEM_SLOT_CPU_MIN_SHARE_EN
  localparam owner_t T4_LAST = OWN_CPU;
`else
  localparam owner_t T4_LAST = OWN_SND;
`endif

  mem_slot_scheduler dut (
    .clk32           (clk32),
    ._reset          (_reset),
    .clk8_en_p       (clk8_en_p),
    .clk8_en_n       (clk8_en_n),
    .video_req       (video_req),
    .snd_req         (snd_req),
    .dsk_int_req     (dsk_int_req),
    .dsk_ext_req     (dsk_ext_req),
    .cpu_req         (cpu_req),
    .videoBusControl (videoBusControl),
    .cpuBusControl   (cpuBusControl),
    .memoryLatch     (memoryLatch),
    .owner           (owner),
    .snd_ack         (snd_ack),
    .dsk_int_ack     (dsk_int_ack),
    .dsk_ext_ack     (dsk_ext_ack),
    .slot_start      (slot_start)
  );

  always #5 clk32 = ~clk32;

  // clk8 phase enables: rising phase, then falling phase two clk32 cycles later.
  initial begin
    int ph;
    ph = 0;
    forever begin
      @(negedge clk32);
      clk8_en_p = (ph == 0);
      clk8_en_n = (ph == 2);
      ph = (ph + 1) % 4;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every latch strobe is matched against the next queued owner.
  always @(negedge clk32) begin
    if (memoryLatch) begin
      latch_cnt++;
      check("latch_window", 32'(latch_forbidden), 32'd0);
      check("sb_nonempty", 32'(sb_q.size() > 0), 32'd1);
      if (sb_q.size() > 0) begin
        mon_exp = sb_q.pop_front();
        check("owner", 32'(owner), 32'(mon_exp));
        check("video_ctl", 32'(videoBusControl), 32'(mon_exp == OWN_VIDEO));
        check("cpu_ctl", 32'(cpuBusControl), 32'(mon_exp == OWN_CPU));
        check("acks", 32'({snd_ack, dsk_int_ack, dsk_ext_ack}),
              32'({mon_exp == OWN_SND, mon_exp == OWN_DSK_INT, mon_exp == OWN_DSK_EXT}));
      end
    end else if (snd_ack || dsk_int_ack || dsk_ext_ack) begin
      check("ack_alone", 32'({snd_ack, dsk_int_ack, dsk_ext_ack}), 32'd0);
    end
  end

  task automatic wait_slot();
    int n;
    n = 0;
    do begin
      @(posedge clk32);
      #1;
      n++;
    end while (!slot_start && n < 64);
    check("slot_start_seen", 32'(slot_start), 32'd1);
  endtask

  // req bits: {video, snd, dsk_int, dsk_ext, cpu}; exp is the owner of the slot these requests win.
  task automatic step(input logic [4:0] req, input owner_t exp);
    {video_req, snd_req, dsk_int_req, dsk_ext_req, cpu_req} = req;
    if (exp != OWN_NONE) begin
      sb_q.push_back(exp);
      push_cnt++;
    end
    wait_slot();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_owner"}, 32'(owner), 32'(OWN_NONE));
    check({tag, "_ctl"}, 32'({videoBusControl, cpuBusControl}), 32'd0);
    check({tag, "_latch"}, 32'(memoryLatch), 32'd0);
    check({tag, "_acks"}, 32'({snd_ack, dsk_int_ack, dsk_ext_ack}), 32'd0);
    check({tag, "_slot_start"}, 32'(slot_start), 32'd0);
  endtask

  initial begin
    int ss;
    int n;
    int latch_base;
    _reset = 1'b0;
    {video_req, snd_req, dsk_int_req, dsk_ext_req, cpu_req} = 5'b0;
    repeat (3) @(posedge clk32);
    #1;
    check_all_zero("reset");
    @(negedge clk32);
    _reset = 1'b1;
    wait_slot();

    // CPU alone owns every slot
    step(5'b00001, OWN_CPU);
    step(5'b00001, OWN_CPU);
    step(5'b00001, OWN_CPU);
    // priority: video, then sound, then CPU as higher requesters drop
    step(5'b11001, OWN_VIDEO);
    step(5'b01001, OWN_SND);
    step(5'b00001, OWN_CPU);
    // disk round-robin
    step(5'b00110, OWN_DSK_INT);
    step(5'b00110, OWN_DSK_EXT);
    step(5'b00110, OWN_DSK_INT);
    step(5'b00010, OWN_DSK_EXT);
    step(5'b00110, OWN_DSK_INT);
    step(5'b00000, OWN_NONE);
    // sound + disk + CPU held: CPU starves, or is forced in every 4th slot
    step(5'b01111, OWN_SND);
    step(5'b01111, OWN_SND);
    step(5'b01111, OWN_SND);
    step(5'b01111, T4_LAST);
    step(5'b01111, OWN_SND);
    step(5'b01111, OWN_SND);
    step(5'b01111, OWN_SND);
    step(5'b01111, T4_LAST);
    step(5'b00000, OWN_NONE);
    step(5'b00000, OWN_NONE);
    check("sb_drained", 32'(sb_q.size()), 32'd0);

    // ten idle slots
    latch_base = latch_cnt;
    ss = 0;
    for (int i = 0; i < 160; i++) begin
      @(posedge clk32);
      #1;
      if (slot_start) ss++;
    end
    check("idle_slot_starts", 32'(ss), 32'd10);
    check("idle_latches", 32'(latch_cnt - latch_base), 32'd0);
    check("idle_owner", 32'(owner), 32'(OWN_NONE));

    // reset at tick 2 of a CPU slot
    cpu_req = 1'b1;
    wait_slot();
    n = 0;
    while (n < 2) begin
      @(posedge clk32);
      if (clk8_en_p) n++;
    end
    #1;
    check("pre_reset_cpu", 32'(cpuBusControl), 32'd1);
    #1;
    latch_forbidden = 1'b1;
    _reset = 1'b0;
    #1;
    check_all_zero("mid_reset");
    repeat (2) @(negedge clk32);
    _reset = 1'b1;
    sb_q.push_back(OWN_CPU);
    push_cnt++;
    wait_slot();
    latch_forbidden = 1'b0;
    step(5'b00000, OWN_NONE);

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    check("latch_count", 32'(latch_cnt), 32'(push_cnt));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
